// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared constants and helpers for the tick scheduler
package tick_pkg;

    // Default build of the scheduler: three channels, 16-bit divisors,
    // 104 MHz / 52 = 2 MHz base tick out of reset.
    localparam int DEF_N_CH      = 3;
    localparam int DEF_DIV_W     = 16;
    localparam int DEF_RESET_DIV = 52;

    // Channel roles in the default build.
    localparam int CH_AUDIO   = 0;
    localparam int CH_SCROLL  = 1;
    localparam int CH_REFRESH = 2;

    // Width of a channel index; a single channel still needs one select bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one tick channel: divider counter, staging register and apply logic
module tick_channel
    import tick_pkg::*;
#(
    parameter int   DIV_W     = DEF_DIV_W,
    parameter int   RESET_DIV = DEF_RESET_DIV,
    parameter logic RESET_EN  = 1'b1
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_src,
    input  logic             i_cfg_we,
    input  logic             i_resync,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic             i_cfg_en,
    output logic             o_tick,
    output logic             o_pending
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_en;
    logic [DIV_W-1:0] r_div_s;
    logic             r_en_s;
    logic             r_pending;
    logic             r_tick;

    logic             w_terminal;

    // Last source strobe of the current period; divisor is never zero here.
    assign w_terminal = (r_cnt == r_div - DIV_W'(1));

    // Counter, tick strobe and staged-configuration hand-over. Staged values
    // only replace the live ones at a period boundary (or while disabled, or
    // on resync) so an in-flight period is never cut short.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_div     <= DIV_W'(RESET_DIV);
            r_en      <= RESET_EN;
            r_div_s   <= DIV_W'(RESET_DIV);
            r_en_s    <= RESET_EN;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_resync) begin
            // Phase-align: restart from zero, suppress this cycle's tick and
            // take any staged value, including one written this very cycle.
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_pending <= 1'b0;
            if (i_cfg_we) begin
                r_div <= i_cfg_div;
                r_en  <= i_cfg_en;
            end else if (r_pending) begin
                r_div <= r_div_s;
                r_en  <= r_en_s;
            end
        end else begin
            if (!r_en) begin
                // Idle channel: nothing to protect, apply staged value at once.
                r_cnt  <= '0;
                r_tick <= 1'b0;
                if (r_pending) begin
                    r_div     <= r_div_s;
                    r_en      <= r_en_s;
                    r_pending <= 1'b0;
                end
            end else if (i_src) begin
                if (w_terminal) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                    if (r_pending) begin
                        r_div     <= r_div_s;
                        r_en      <= r_en_s;
                        r_pending <= 1'b0;
                    end
                end else begin
                    r_cnt  <= r_cnt + DIV_W'(1);
                    r_tick <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
            end

            // The handshake only writes a channel with nothing staged, so
            // this never collides with an apply above.
            if (i_cfg_we) begin
                r_div_s   <= i_cfg_div;
                r_en_s    <= i_cfg_en;
                r_pending <= 1'b1;
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_pending = r_pending;

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - clock-enable scheduler with cascadable channels and runtime reconfiguration
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int              N_CH      = DEF_N_CH,
    parameter int              DIV_W     = DEF_DIV_W,
    parameter int              RESET_DIV = DEF_RESET_DIV,
    parameter logic [N_CH-1:0] RESET_EN  = {N_CH{1'b1}},
    parameter logic [N_CH-1:0] CASCADE   = N_CH'(3'b010),
    localparam int             CH_W      = ch_width(N_CH)
)(
    input  logic             clock_104mhz,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_en,
    input  logic             resync,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pending,
    output logic             cfg_err
);

    logic            w_ready;
    logic            w_accept;
    logic            w_ch_ok;
    logic            w_div_ok;
    logic [N_CH-1:0] w_cfg_we;
    logic [N_CH-1:0] w_src;
    logic [N_CH-1:0] w_tick;
    logic [N_CH-1:0] w_pending;
    logic            r_cfg_err;

    assign w_ch_ok  = (int'(cfg_ch) < N_CH);
    assign w_div_ok = (cfg_div != '0);
    assign w_accept = cfg_valid && w_ready;

    // Ready follows the addressed channel's staging slot; a request to a
    // nonexistent channel is always taken so it can be flagged and dropped.
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(cfg_ch) == i) begin
                w_ready = !w_pending[i];
            end
        end
    end

    // Route an accepted, well-formed request to its channel's staging register.
    always_comb begin
        w_cfg_we = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_cfg_we[i] = w_accept && w_div_ok && (int'(cfg_ch) == i);
        end
    end

    // Sticky flag for any consumed request that could not be applied.
    always_ff @(posedge clock_104mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_err <= 1'b0;
        end else if (w_accept && !(w_ch_ok && w_div_ok)) begin
            r_cfg_err <= 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            // Cascaded channels count their predecessor's strobes; the rest
            // count fabric clock cycles.
            if (g == 0) begin : g_src_clk
                assign w_src[g] = 1'b1;
            end else begin : g_src_sel
                assign w_src[g] = CASCADE[g] ? w_tick[g-1] : 1'b1;
            end

            tick_channel #(
                .DIV_W     (DIV_W),
                .RESET_DIV (RESET_DIV),
                .RESET_EN  (RESET_EN[g])
            ) u_channel (
                .i_clk     (clock_104mhz),
                .i_rst_n   (reset_n),
                .i_src     (w_src[g]),
                .i_cfg_we  (w_cfg_we[g]),
                .i_resync  (resync),
                .i_cfg_div (cfg_div),
                .i_cfg_en  (cfg_en),
                .o_tick    (w_tick[g]),
                .o_pending (w_pending[g])
            );
        end
    endgenerate

    assign cfg_ready = w_ready;
    assign tick      = w_tick;
    assign pending   = w_pending;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - scoreboard bench for tick_scheduler against a strobe-counting reference model
module tb_tick_scheduler;

    localparam int N = 3;

    logic        clock_104mhz = 1'b0;
    logic        reset_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_en;
    logic        resync;
    logic [2:0]  tick;
    logic [2:0]  pending;
    logic        cfg_err;

    always #5 clock_104mhz = ~clock_104mhz;

    tick_scheduler dut (
        .clock_104mhz (clock_104mhz),
        .reset_n      (reset_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_en       (cfg_en),
        .resync       (resync),
        .tick         (tick),
        .pending      (pending),
        .cfg_err      (cfg_err)
    );

    typedef struct {
        logic [2:0] tick;
        logic [2:0] pend;
        logic       err;
        logic       ready;
    } exp_t;

    exp_t q[$];
    exp_t it;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    // Reference model: each channel remembers how many source strobes it has
    // seen since it last restarted; a tick is due on every multiple of D.
    bit cas[N] = '{1'b0, 1'b1, 1'b0};
    int m_div[N];
    int m_div_s[N];
    int m_n[N];
    bit m_en[N];
    bit m_en_s[N];
    bit m_pend[N];
    bit m_tick[N];
    bit m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_div[i]   = 52;
            m_div_s[i] = 52;
            m_n[i]     = 0;
            m_en[i]    = 1'b1;
            m_en_s[i]  = 1'b1;
            m_pend[i]  = 1'b0;
            m_tick[i]  = 1'b0;
        end
        m_err = 1'b0;
    endtask

    function automatic bit m_ready(input int ch);
        return (ch < N) ? !m_pend[ch] : 1'b1;
    endfunction

    task automatic m_advance(input bit v, input int ch, input int d, input bit e, input bit rs);
        bit old_tick[N];
        bit acc, we_i, src, apply;
        old_tick = m_tick;
        acc = v && m_ready(ch);
        if (acc && (ch >= N || d == 0)) m_err = 1'b1;
        for (int i = 0; i < N; i++) begin
            we_i = acc && (ch == i) && (d != 0);
            src  = (i > 0 && cas[i]) ? old_tick[i-1] : 1'b1;
            if (rs) begin
                m_n[i]    = 0;
                m_tick[i] = 1'b0;
                if (we_i) begin
                    m_div[i] = d;
                    m_en[i]  = e;
                end else if (m_pend[i]) begin
                    m_div[i] = m_div_s[i];
                    m_en[i]  = m_en_s[i];
                end
                m_pend[i] = 1'b0;
            end else begin
                apply = 1'b0;
                if (!m_en[i]) begin
                    m_n[i]    = 0;
                    m_tick[i] = 1'b0;
                    apply     = m_pend[i];
                end else if (src) begin
                    m_n[i]    = m_n[i] + 1;
                    m_tick[i] = (m_n[i] % m_div[i]) == 0;
                    apply     = m_tick[i] && m_pend[i];
                end else begin
                    m_tick[i] = 1'b0;
                end
                if (apply) begin
                    m_div[i]  = m_div_s[i];
                    m_en[i]   = m_en_s[i];
                    m_n[i]    = 0;
                    m_pend[i] = 1'b0;
                end
                if (we_i) begin
                    m_div_s[i] = d;
                    m_en_s[i]  = e;
                    m_pend[i]  = 1'b1;
                end
            end
        end
    endtask

    // One cycle of stimulus: drive inputs just after the edge, record what the
    // outputs must read for the rest of this cycle, then step the model.
    task automatic step(input bit rn, input bit v, input int ch, input int d, input bit e, input bit rs);
        exp_t x;
        @(posedge clock_104mhz);
        #2;
        reset_n   = rn;
        cfg_valid = v;
        cfg_ch    = 2'(ch);
        cfg_div   = 16'(d);
        cfg_en    = e;
        resync    = rs;
        if (!rn) m_reset();
        for (int i = 0; i < N; i++) begin
            x.tick[i] = m_tick[i];
            x.pend[i] = m_pend[i];
        end
        x.err   = m_err;
        x.ready = m_ready(ch);
        q.push_back(x);
        n_push++;
        if (rn) m_advance(v, ch, d, e, rs);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 0, 1, 1'b1, 1'b0);
    endtask

    task automatic wr(input int ch, input int d, input bit e, input bit rs);
        step(1'b1, 1'b1, ch, d, e, rs);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    initial begin
        forever begin
            @(negedge clock_104mhz);
            if (q.size() > 0) begin
                it = q.pop_front();
                n_pop++;
                chk("tick",      32'(tick),      32'(it.tick));
                chk("pending",   32'(pending),   32'(it.pend));
                chk("cfg_err",   32'(cfg_err),   32'(it.err));
                chk("cfg_ready", 32'(cfg_ready), 32'(it.ready));
            end
        end
    end

    initial begin
        bit v, e, rs, rn;
        int ch, d;
        reset_n   = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = 16'd1;
        cfg_en    = 1'b1;
        resync    = 1'b0;
        m_reset();

        // Reset held, then defaults long enough for a cascaded ch1 tick.
        repeat (3) step(1'b0, 1'b0, 0, 1, 1'b1, 1'b0);
        idle(2800);

        // ch0 D=10 mid-period, then a second write held while pending.
        idle(20);
        wr(0, 10, 1'b1, 1'b0);
        repeat (40) wr(0, 7, 1'b1, 1'b0);
        idle(60);

        // ch2 disable, then re-enable with D=5.
        wr(2, 52, 1'b0, 1'b0);
        idle(70);
        wr(2, 5, 1'b1, 1'b0);
        idle(30);

        // resync together with a ch0 write.
        idle(30);
        wr(0, 8, 1'b1, 1'b1);
        idle(40);

        // Malformed requests: out-of-range channel and zero divisor.
        wr(3, 4, 1'b1, 1'b0);
        wr(1, 0, 1'b1, 1'b0);
        idle(120);

        // Reset pulse mid-count, then default timing again.
        step(1'b0, 1'b0, 0, 1, 1'b1, 1'b0);
        idle(120);

        // Randomized traffic.
        repeat (6000) begin
            v  = ($urandom_range(0, 99) < 15);
            ch = $urandom_range(0, 3);
            d  = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 9);
            e  = ($urandom_range(0, 9) != 0);
            rs = ($urandom_range(0, 199) == 0);
            rn = ($urandom_range(0, 999) != 0);
            step(rn, v, ch, d, e, rs);
        end
        idle(2);

        @(posedge clock_104mhz);
        @(posedge clock_104mhz);
        chk("drain", 32'(n_pop), 32'(n_push));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Programmable clock-enable scheduler for the 104 MHz fabric clock. It replaces derived clocks with single-cycle enable strobes, one per consumer channel: audio sample tick, note-scroll tick and display refresh. Channels can cascade, so one channel counts another channel's ticks instead of clock cycles. Divisors and enables are reconfigured at run time through a valid/ready handshake without glitching the tick stream.

## Interface
Parameters:
- N_CH, 3, number of tick channels (1..8)
- DIV_W, 16, divisor width
- RESET_DIV, 52, divisor loaded into every channel at reset
- RESET_EN, {N_CH{1'b1}}, per-channel enable at reset
- CASCADE, 3'b010, bit i=1 means channel i counts tick[i-1] strobes; bit 0 is ignored

Ports (one clock; reset is asynchronous and active-low):
- clock_104mhz  in  1  system clock, all logic on rising edge
- reset_n  in  1  async active-low reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  request may be accepted this cycle
- cfg_ch  in  CH_W=max(1,$clog2(N_CH))  target channel
- cfg_div  in  DIV_W  new divisor, must be ≥1
- cfg_en  in  1  new enable for the target channel
- resync  in  1  one-cycle pulse that phase-aligns all channels
- tick  out  N_CH  one-cycle enable strobes
- pending  out  N_CH  staged configuration not yet applied
- cfg_err  out  1  sticky error flag, cleared only by reset

## Operation
- Per-channel state: cnt[DIV_W], div[DIV_W], en, staged div_s/en_s, pending, tick register.
- Source strobe src[i] is tick[i-1] when CASCADE[i]=1 and i>0. Otherwise src[i]=1 every cycle.
- Counting, when en=1 and src[i]=1:
  - if cnt==div-1: cnt←0, tick[i]←1 next cycle
  - else: cnt←cnt+1, tick[i]←0
- When src[i]=0, cnt holds and tick[i]←0.
- Disabled channel: cnt←0, tick[i]←0.
- cfg_ready = !pending[cfg_ch] for an in-range cfg_ch, and 1 for an out-of-range cfg_ch.
- Accept occurs on cfg_valid & cfg_ready:
  - Valid request (cfg_ch<N_CH, cfg_div≠0): div_s←cfg_div, en_s←cfg_en, pending←1.
  - cfg_ch≥N_CH or cfg_div==0: request is consumed, channel state is unchanged, cfg_err←1.
- Apply, when pending=1 (div←div_s, en←en_s, cnt←0, pending←0):
  - on the terminal-count cycle of an enabled channel; the tick for that terminal count still fires
  - on the cycle after accept if the channel is currently disabled
  - on resync
- resync, for all channels in the same cycle:
  - cnt←0, and no tick is produced from that cycle
  - every pending channel applies its staged value, including one accepted in the same cycle
- Divisor value D gives a period of D source strobes. With D=1 and an uncascaded channel, tick is constantly high.

## Timing
- Reset values: tick=0, pending=0, cfg_err=0, cnt=0, div=RESET_DIV, en=RESET_EN. cfg_ready therefore reads 1.
- Uncascaded channel after reset release: the first tick is high in the cycle after rising edge D, with period D cycles.
- Each cascade level adds 1 cycle of phase latency. Channel 1 with D1 on channel 0 with D0 has period D0·D1 cycles.
- Accept to pending=1 takes 1 cycle. pending falls in the same cycle the new div takes effect.
- Configuration change is glitch-free: no tick interval is ever shorter than min(old D, new D) source strobes, except when resync is asserted.
- Async reset mid-count: outputs go to reset values immediately, and counting restarts from 0 after release.
- Register every output except cfg_ready, which is combinational from cfg_ch and pending.

## Structure
- Shared package tick_pkg holds:
  - default constants: N_CH, DIV_W, RESET_DIV
  - channel index localparams: CH_AUDIO=0, CH_SCROLL=1, CH_REFRESH=2
- Sub-module tick_channel contains one channel's counter, staging register and apply logic. Its inputs are src, cfg_we, resync and the staged values; its outputs are tick and pending.
- The top level instantiates tick_channel in a generate loop, wires the cascade sources and holds the handshake and cfg_err logic.

## Test plan
- Reset defaults (N_CH=3, D=52, ch1 cascaded): ch0 ticks every 52 cycles. ch1 ticks every 2704 cycles, 1 cycle after every 52nd ch0 tick.
- Write ch0 D=10 at cnt=20: pending=1 and cfg_ready=0 for ch0 until the terminal count at cnt=51. After that, ticks come every 10 cycles with no short interval. A second write to ch0 while pending stalls until pending clears.
- Write ch2 en=0, then en=1 with D=5: tick[2] goes quiet on the following terminal count. The re-enable applies on the cycle after accept, and the first tick follows 5 cycles later.
- Pulse resync with ch0 at cnt=30 while a ch0 write of D=8 is accepted in the same cycle: no tick in that cycle, pending clears, and ch0 ticks 8 cycles later. All channels are then phase-aligned.
- Write cfg_ch=3, then cfg_div=0: both are accepted with cfg_ready=1, cfg_err rises and stays high, and all tick periods are unchanged.
- Assert reset_n low for 1 cycle mid-count: tick, pending and cfg_err go to 0 asynchronously. After release, the D=52 first-tick timing matches the defaults scenario.
